double_frame_buffer: RTL and testbench

// - Two-bank 1-bpp frame store between the pixel writer (pattern/game renderer) and the VGA scanout.
// - Writer fills the back bank via wr_en/wr_addr/wr_data; scanout reads the front bank via rd_en/rd_addr.
// - At a frame boundary, after a complete write burst, the banks swap. swap is pulsed back to the

---
 rtl/fb_pkg.sv | 16 +
 rtl/bit_ram.sv | 33 +++
 rtl/double_frame_buffer.sv | 105 ++++++++++
 tb/tb_double_frame_buffer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared types and sizing helpers for the double frame buffer
package fb_pkg;

    typedef enum logic [1:0] {
        WAIT_WR = 2'd0,
        WRITING = 2'd1,
        READY   = 2'd2
    } fb_state_t;

    localparam int FB_PIXELS = 640 * 480;

    function automatic int fb_addr_width(input int pixels);
        return (pixels > 1) ? $clog2(pixels) : 1;
    endfunction

endpackage

// File: rtl/bit_ram.sv
// rtl/bit_ram.sv - 1-bit simple dual-port RAM, one write port and one registered read port
module bit_ram #(
    parameter int DEPTH      = 2,
    parameter int ADDR_WIDTH = 1
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic                  wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic                  rdata_o
);

    logic mem [DEPTH];
    logic rdata_q;

    // No reset on storage or read register so the array maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/double_frame_buffer.sv
// rtl/double_frame_buffer.sv - two-bank 1-bpp frame store with frame-boundary bank swap
module double_frame_buffer
    import fb_pkg::*;
#(
    parameter  int HOR_ACTIVE_PIXELS = 640,
    parameter  int VER_ACTIVE_PIXELS = 480,
    localparam int PIXELS            = HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS,
    localparam int ADDR_WIDTH        = fb_addr_width(PIXELS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic                  wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_data,
    input  logic                  frame_end,
    output logic                  swap,
    output logic                  front_bank
);

    localparam logic [ADDR_WIDTH:0] PIX_LIM = (ADDR_WIDTH + 1)'(PIXELS);

    fb_state_t state_q, state_d;
    logic      swap_q, swap_d;
    logic      front_q, front_d;
    logic      rd_ok_q, rd_bank_q;
    logic      wr_ok, rd_ok;
    logic      rdata0, rdata1;

    // Writes in the reset cycle are dropped; reads are gated too so the RAM read
    // register never captures anything the output mask would not hide.
    assign wr_ok = rst_n && wr_en && ({1'b0, wr_addr} < PIX_LIM);
    assign rd_ok = rst_n && rd_en && ({1'b0, rd_addr} < PIX_LIM);

    bit_ram #(.DEPTH(PIXELS), .ADDR_WIDTH(ADDR_WIDTH)) u_bank0 (
        .clk_i   (clk),
        .we_i    (wr_ok && front_q),
        .waddr_i (wr_addr),
        .wdata_i (wr_data),
        .re_i    (rd_ok && !front_q),
        .raddr_i (rd_addr),
        .rdata_o (rdata0)
    );

    bit_ram #(.DEPTH(PIXELS), .ADDR_WIDTH(ADDR_WIDTH)) u_bank1 (
        .clk_i   (clk),
        .we_i    (wr_ok && !front_q),
        .waddr_i (wr_addr),
        .wdata_i (wr_data),
        .re_i    (rd_ok && front_q),
        .raddr_i (rd_addr),
        .rdata_o (rdata1)
    );

    always_comb begin
        state_d = state_q;
        swap_d  = 1'b0;
        front_d = front_q;
        case (state_q)
            WAIT_WR: if (wr_en) state_d = WRITING;
            WRITING: if (!wr_en) state_d = READY;
            READY: begin
                // A restarted burst beats a coincident frame_end.
                if (wr_en) begin
                    state_d = WRITING;
                end else if (frame_end) begin
                    swap_d  = 1'b1;
                    front_d = ~front_q;
                    state_d = WAIT_WR;
                end
            end
            default: state_d = WAIT_WR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= WAIT_WR;
            swap_q  <= 1'b0;
            front_q <= 1'b0;
        end else begin
            state_q <= state_d;
            swap_q  <= swap_d;
            front_q <= front_d;
        end
    end

    // Bank and range of the last accepted read; captured with the pre-swap bank.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ok_q   <= 1'b0;
            rd_bank_q <= 1'b0;
        end else if (rd_en) begin
            rd_ok_q   <= rd_ok;
            rd_bank_q <= front_q;
        end
    end

    assign rd_data    = rd_ok_q & (rd_bank_q ? rdata1 : rdata0);
    assign swap       = swap_q;
    assign front_bank = front_q;

endmodule

// File: tb/tb_double_frame_buffer.sv
// tb/tb_double_frame_buffer.sv - directed self-checking bench for double_frame_buffer
module tb_double_frame_buffer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0, wr_data = 1'b0, rd_en = 1'b0, frame_end = 1'b0;
    logic [4:0] wr_addr = '0, rd_addr = '0;
    logic       rd_data, swap, front_bank;

    logic       wr_en2 = 1'b0, wr_data2 = 1'b0, rd_en2 = 1'b0, frame_end2 = 1'b0;
    logic [4:0] wr_addr2 = '0, rd_addr2 = '0;
    logic       rd_data2, swap2, front_bank2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    double_frame_buffer #(.HOR_ACTIVE_PIXELS(8), .VER_ACTIVE_PIXELS(4)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .frame_end(frame_end), .swap(swap), .front_bank(front_bank)
    );

    // 24-pixel instance leaves addresses 24..31 out of range for the bounds checks.
    double_frame_buffer #(.HOR_ACTIVE_PIXELS(8), .VER_ACTIVE_PIXELS(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
        .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_data(rd_data2),
        .frame_end(frame_end2), .swap(swap2), .front_bank(front_bank2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; frame_end = 1'b1; frame_end2 = 1'b1; wr_en = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            n_cmp++; if (swap !== 1'b0) begin n_bad++; $display("FAIL reset_swap got=%b exp=0", swap); end
            n_cmp++; if (front_bank !== 1'b0) begin n_bad++; $display("FAIL reset_front got=%b exp=0", front_bank); end
            n_cmp++; if (rd_data !== 1'b0) begin n_bad++; $display("FAIL reset_rd_data got=%b exp=0", rd_data); end
            n_cmp++; if (swap2 !== 1'b0) begin n_bad++; $display("FAIL reset_swap2 got=%b exp=0", swap2); end
        end
        rst_n = 1'b1; frame_end = 1'b0; frame_end2 = 1'b0; wr_en = 1'b0;
        tick();
        n_cmp++; if (rd_data !== 1'b0) begin n_bad++; $display("FAIL reset_rd_hold got=%b exp=0", rd_data); end
    endtask

    task automatic test_full_burst();
        for (int i = 0; i < 32; i++) begin
            wr_en = 1'b1; wr_addr = 5'(i); wr_data = i[0];
            tick();
            n_cmp++; if (swap !== 1'b0) begin n_bad++; $display("FAIL burst_swap addr=%0d got=%b exp=0", i, swap); end
        end
        wr_en = 1'b0;
        tick();
        n_cmp++; if (swap !== 1'b0) begin n_bad++; $display("FAIL burst_drop_swap got=%b exp=0", swap); end
        frame_end = 1'b1;
        tick();
        n_cmp++; if (swap !== 1'b1) begin n_bad++; $display("FAIL burst_swap_pulse got=%b exp=1", swap); end
        n_cmp++; if (front_bank !== 1'b1) begin n_bad++; $display("FAIL burst_front got=%b exp=1", front_bank); end
        frame_end = 1'b0;
        tick();
        n_cmp++; if (swap !== 1'b0) begin n_bad++; $display("FAIL burst_swap_once got=%b exp=0", swap); end
        n_cmp++; if (front_bank !== 1'b1) begin n_bad++; $display("FAIL burst_front_hold got=%b exp=1", front_bank); end
        for (int i = 0; i < 32; i++) begin
            rd_en = 1'b1; rd_addr = 5'(i);
            tick();
            n_cmp++; if (rd_data !== i[0]) begin n_bad++; $display("FAIL burst_read addr=%0d got=%b exp=%b", i, rd_data, i[0]); end
        end
        rd_en = 1'b0; rd_addr = 5'd0;
        tick(); tick();
        n_cmp++; if (rd_data !== 1'b1) begin n_bad++; $display("FAIL read_hold got=%b exp=1", rd_data); end
    endtask

    task automatic test_frame_end_writing();
        logic exp;
        for (int i = 0; i < 32; i++) begin
            wr_en = 1'b1; wr_addr = 5'(i); wr_data = ~i[0]; frame_end = (i == 10);
            tick();
            n_cmp++; if (swap !== 1'b0) begin n_bad++; $display("FAIL writing_swap addr=%0d got=%b exp=0", i, swap); end
            n_cmp++; if (front_bank !== 1'b1) begin n_bad++; $display("FAIL writing_front addr=%0d got=%b exp=1", i, front_bank); end
        end
        wr_en = 1'b0; frame_end = 1'b0;
        tick();
        frame_end = 1'b1;
        tick();
        n_cmp++; if (swap !== 1'b1) begin n_bad++; $display("FAIL writing_late_swap got=%b exp=1", swap); end
        n_cmp++; if (front_bank !== 1'b0) begin n_bad++; $display("FAIL writing_late_front got=%b exp=0", front_bank); end
        frame_end = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rd_en = 1'b1; rd_addr = 5'(i); exp = ~i[0];
            tick();
            n_cmp++; if (rd_data !== exp) begin n_bad++; $display("FAIL writing_read addr=%0d got=%b exp=%b", i, rd_data, exp); end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_ready_collision();
        for (int i = 0; i < 32; i++) begin
            wr_en = 1'b1; wr_addr = 5'(i); wr_data = 1'b1;
            tick();
        end
        wr_en = 1'b0;
        tick();
        wr_en = 1'b1; frame_end = 1'b1; wr_addr = 5'd0; wr_data = 1'b1;
        tick();
        n_cmp++; if (swap !== 1'b0) begin n_bad++; $display("FAIL collide_swap got=%b exp=0", swap); end
        n_cmp++; if (front_bank !== 1'b0) begin n_bad++; $display("FAIL collide_front got=%b exp=0", front_bank); end
        wr_en = 1'b0; frame_end = 1'b1;
        tick();
        n_cmp++; if (swap !== 1'b0) begin n_bad++; $display("FAIL collide_in_writing got=%b exp=0", swap); end
        frame_end = 1'b0;
        tick();
        frame_end = 1'b1;
        tick();
        n_cmp++; if (swap !== 1'b1) begin n_bad++; $display("FAIL collide_late_swap got=%b exp=1", swap); end
        n_cmp++; if (front_bank !== 1'b1) begin n_bad++; $display("FAIL collide_late_front got=%b exp=1", front_bank); end
        frame_end = 1'b0; rd_en = 1'b1; rd_addr = 5'd5;
        tick();
        n_cmp++; if (rd_data !== 1'b1) begin n_bad++; $display("FAIL collide_read got=%b exp=1", rd_data); end
        rd_en = 1'b0;
    endtask

    task automatic test_isolation();
        for (int i = 0; i < 32; i++) begin
            wr_en = 1'b1; wr_addr = 5'(i); wr_data = 1'b0;
            tick();
        end
        wr_en = 1'b0;
        tick();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        n_cmp++; if (front_bank !== 1'b0) begin n_bad++; $display("FAIL iso_front_zero got=%b exp=0", front_bank); end
        for (int i = 0; i < 32; i++) begin
            wr_en = 1'b1; wr_addr = 5'(i); wr_data = 1'b1;
            rd_en = 1'b1; rd_addr = 5'(i);
            tick();
            n_cmp++; if (rd_data !== 1'b0) begin n_bad++; $display("FAIL iso_read addr=%0d got=%b exp=0", i, rd_data); end
        end
        wr_en = 1'b0; rd_en = 1'b0;
        tick();
        frame_end = 1'b1; rd_en = 1'b1; rd_addr = 5'd7;
        tick();
        n_cmp++; if (swap !== 1'b1) begin n_bad++; $display("FAIL iso_swap got=%b exp=1", swap); end
        n_cmp++; if (rd_data !== 1'b0) begin n_bad++; $display("FAIL iso_swap_cycle_read got=%b exp=0", rd_data); end
        frame_end = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rd_addr = 5'(i);
            tick();
            n_cmp++; if (rd_data !== 1'b1) begin n_bad++; $display("FAIL iso_after_read addr=%0d got=%b exp=1", i, rd_data); end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_addr = 5'(i); wr_data = 1'b1; rst_n = (i != 15);
            tick();
        end
        n_cmp++; if (front_bank !== 1'b0) begin n_bad++; $display("FAIL midrst_front got=%b exp=0", front_bank); end
        n_cmp++; if (rd_data !== 1'b0) begin n_bad++; $display("FAIL midrst_rd_data got=%b exp=0", rd_data); end
        rst_n = 1'b1; wr_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            frame_end = 1'b1;
            tick();
            n_cmp++; if (swap !== 1'b0) begin n_bad++; $display("FAIL midrst_no_swap k=%0d got=%b exp=0", k, swap); end
            frame_end = 1'b0;
            tick();
        end
        rd_en = 1'b1; rd_addr = 5'd3;
        tick();
        n_cmp++; if (rd_data !== 1'b1) begin n_bad++; $display("FAIL midrst_kept_addr3 got=%b exp=1", rd_data); end
        rd_addr = 5'd15;
        tick();
        n_cmp++; if (rd_data !== 1'b0) begin n_bad++; $display("FAIL midrst_dropped_addr15 got=%b exp=0", rd_data); end
        rd_addr = 5'd20;
        tick();
        n_cmp++; if (rd_data !== 1'b0) begin n_bad++; $display("FAIL midrst_addr20 got=%b exp=0", rd_data); end
        rd_en = 1'b0;
        for (int i = 0; i < 32; i++) begin
            wr_en = 1'b1; wr_addr = 5'(i); wr_data = i[0];
            tick();
        end
        wr_en = 1'b0;
        tick();
        frame_end = 1'b1;
        tick();
        n_cmp++; if (swap !== 1'b1) begin n_bad++; $display("FAIL midrst_new_swap got=%b exp=1", swap); end
        n_cmp++; if (front_bank !== 1'b1) begin n_bad++; $display("FAIL midrst_new_front got=%b exp=1", front_bank); end
        frame_end = 1'b0; rd_en = 1'b1; rd_addr = 5'd9;
        tick();
        n_cmp++; if (rd_data !== 1'b1) begin n_bad++; $display("FAIL midrst_read9 got=%b exp=1", rd_data); end
        rd_addr = 5'd8;
        tick();
        n_cmp++; if (rd_data !== 1'b0) begin n_bad++; $display("FAIL midrst_read8 got=%b exp=0", rd_data); end
        rd_en = 1'b0;
    endtask

    task automatic test_range();
        logic [4:0] addrs [6];
        logic       exps  [6];
        addrs = '{5'd5, 5'd24, 5'd0, 5'd31, 5'd23, 5'd7};
        exps  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 32; i++) begin
            wr_en2 = 1'b1; wr_addr2 = 5'(i); wr_data2 = (i < 24);
            tick();
        end
        wr_en2 = 1'b0;
        tick();
        frame_end2 = 1'b1;
        tick();
        n_cmp++; if (swap2 !== 1'b1) begin n_bad++; $display("FAIL range_swap got=%b exp=1", swap2); end
        n_cmp++; if (front_bank2 !== 1'b1) begin n_bad++; $display("FAIL range_front got=%b exp=1", front_bank2); end
        frame_end2 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            rd_en2 = 1'b1; rd_addr2 = addrs[k];
            tick();
            n_cmp++; if (rd_data2 !== exps[k]) begin n_bad++; $display("FAIL range_read addr=%0d got=%b exp=%b", addrs[k], rd_data2, exps[k]); end
        end
        rd_en2 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_burst();
        test_frame_end_writing();
        test_ready_collision();
        test_isolation();
        test_mid_reset();
        test_range();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
